// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
package uart_pkg;
   localparam int OVERSAMPLE = 16;

   typedef enum logic [1:0] {NONE = 2'd0, ODD = 2'd1, EVEN = 2'd2} parity_e;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_e;

   // Tick divisor rounded to nearest: clk_hz / (baud * OVERSAMPLE).
   function automatic int uart_div(input int clk_hz, input int baud);
      return (clk_hz + baud * (OVERSAMPLE / 2)) / (baud * OVERSAMPLE);
   endfunction
endpackage

// File: rtl/uart_rx_os_if.sv
// Receiver output stream: head-of-FIFO entry with valid/ready handshake.
interface uart_rx_os_if #(parameter int DATA_BITS = 8);
   logic [DATA_BITS-1:0] out_data;
   logic                 out_parity_err;
   logic                 out_frame_err;
   logic                 out_valid;
   logic                 out_ready;

   modport master (output out_data, out_parity_err, out_frame_err, out_valid,
                   input  out_ready);
   modport slave  (input  out_data, out_parity_err, out_frame_err, out_valid,
                   output out_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO; a push while full succeeds only with a same-cycle pop.
module uart_rx_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);
   localparam int AW = $clog2(DEPTH);

   if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_depth_err
      $error("uart_rx_fifo: DEPTH must be a power of two >= 2");
   end

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr;
   logic             wr_en, rd_en;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_en = pop & ~empty;
   assign wr_en = push & (~full | rd_en);
   assign head  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
   end
endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampling UART receiver: synchroniser, tick generator, frame FSM, output FIFO.
//   state     | meaning
//   IDLE      | line idle, waiting for a falling edge
//   START     | verifying start bit at its mid-point
//   DATA      | sampling DATA_BITS bits, LSB first
//   PARITY    | sampling the parity bit
//   STOP      | sampling STOP_BITS stop bits
//   WAIT_HIGH | frame error seen, waiting for the line to return high
module uart_rx_os #(
   parameter int CLK_HZ     = 100_000_000,
   parameter int BAUD0      = 9600,
   parameter int BAUD1      = 19200,
   parameter int BAUD2      = 57600,
   parameter int BAUD3      = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         rx_input,
   input  logic [1:0]   brate_selection,
   uart_rx_os_if.master rx_out,
   output logic         overrun,
   input  logic         clr_overrun,
   output logic         busy
);
   import uart_pkg::*;

   localparam int DIV_W = 16;
   localparam int DIV0  = uart_div(CLK_HZ, BAUD0);
   localparam int DIV1  = uart_div(CLK_HZ, BAUD1);
   localparam int DIV2  = uart_div(CLK_HZ, BAUD2);
   localparam int DIV3  = uart_div(CLK_HZ, BAUD3);
   localparam int FW    = DATA_BITS + 2;
   localparam parity_e PAR = parity_e'(PARITY);

   if (DIV0 < 1 || DIV1 < 1 || DIV2 < 1 || DIV3 < 1 ||
       DIV0 >= (1 << DIV_W) || DIV1 >= (1 << DIV_W) ||
       DIV2 >= (1 << DIV_W) || DIV3 >= (1 << DIV_W)) begin : g_div_err
      $error("uart_rx_os: baud divisor out of range");
   end
   if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
       STOP_BITS < 1 || STOP_BITS > 2) begin : g_frame_err
      $error("uart_rx_os: unsupported frame format");
   end

   logic [1:0]           sync_q;
   logic                 rxs, rxs_d, fall;
   state_e               state, state_n;
   logic [DIV_W-1:0]     div_sel, div_q, tick_cnt;
   logic [3:0]           os_cnt;
   logic [2:0]           bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 parity_err, frame_err, push_q;
   logic                 tick, sample, last_bit, exp_par;
   logic                 fifo_full, fifo_empty, pop;
   logic [FW-1:0]        head;

   assign rxs      = sync_q[1];
   assign fall     = rxs_d & ~rxs;
   assign tick     = (state != IDLE) && (tick_cnt == '0);
   assign sample   = tick && (os_cnt == '0);
   assign last_bit = (bit_cnt == '0);
   assign exp_par  = (PAR == EVEN) ? ^shreg : ~^shreg;
   assign busy     = (state != IDLE);

   always_comb begin
      div_sel = DIV_W'(DIV3);
      case (brate_selection)
         2'd0:    div_sel = DIV_W'(DIV0);
         2'd1:    div_sel = DIV_W'(DIV1);
         2'd2:    div_sel = DIV_W'(DIV2);
         default: div_sel = DIV_W'(DIV3);
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
         rxs_d  <= 1'b1;
      end else begin
         sync_q <= {sync_q[0], rx_input};
         rxs_d  <= rxs;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:      if (fall) state_n = START;
         START:     if (sample) state_n = rxs ? IDLE : DATA;
         DATA:      if (sample && last_bit) state_n = (PAR != NONE) ? uart_pkg::PARITY : STOP;
         uart_pkg::PARITY: if (sample) state_n = STOP;
         STOP:      if (sample && last_bit) state_n = (frame_err | ~rxs) ? WAIT_HIGH : IDLE;
         WAIT_HIGH: if (rxs) state_n = IDLE;
         default:   state_n = IDLE;
      endcase
   end

   // The divisor is captured on the start edge so baud changes only apply to the next frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q      <= '0;
         tick_cnt   <= '0;
         os_cnt     <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         push_q     <= 1'b0;
      end else begin
         push_q <= 1'b0;
         if (state == IDLE) begin
            if (fall) begin
               div_q    <= div_sel;
               tick_cnt <= div_sel - 1'b1;
               os_cnt   <= 4'(OVERSAMPLE / 2 - 1);
            end
         end else begin
            tick_cnt <= tick ? div_q - 1'b1 : tick_cnt - 1'b1;
            if (tick) os_cnt <= (os_cnt == '0) ? 4'(OVERSAMPLE - 1) : os_cnt - 1'b1;
         end
         if (sample) begin
            case (state)
               START: if (!rxs) begin
                  bit_cnt    <= 3'(DATA_BITS - 1);
                  parity_err <= 1'b0;
                  frame_err  <= 1'b0;
               end
               DATA: begin
                  shreg   <= {rxs, shreg[DATA_BITS-1:1]};
                  bit_cnt <= last_bit ? 3'(STOP_BITS - 1) : bit_cnt - 1'b1;
               end
               uart_pkg::PARITY: parity_err <= (rxs != exp_par);
               STOP: begin
                  if (!rxs) frame_err <= 1'b1;
                  if (last_bit) push_q <= 1'b1;
                  else          bit_cnt <= bit_cnt - 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign pop = ~fifo_empty & rx_out.out_ready;

   uart_rx_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_q),
      .pop   (pop),
      .din   ({shreg, parity_err, frame_err}),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (head)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              overrun <= 1'b0;
      else if (push_q && fifo_full && !pop)    overrun <= 1'b1;
      else if (clr_overrun)                    overrun <= 1'b0;
   end

   assign rx_out.out_valid      = ~fifo_empty;
   assign rx_out.out_data       = fifo_empty ? '0 : head[FW-1:2];
   assign rx_out.out_parity_err = fifo_empty ? 1'b0 : head[1];
   assign rx_out.out_frame_err  = fifo_empty ? 1'b0 : head[0];
endmodule

// File: tb/tb_uart_rx_os.sv
// Directed plus randomized bench for uart_rx_os: dut_a is 8N1 with a 4-deep FIFO, dut_b is 8E2.
module tb_uart_rx_os;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx_a, rx_b;
   logic [1:0] sel_a, sel_b;
   logic       clr_a, clr_b;
   logic       ovr_a, ovr_b, busy_a, busy_b;
   int         checks = 0;
   int         failures = 0;

   typedef struct packed {logic [7:0] d; logic pe; logic fe;} ent_t;
   ent_t exp_q[$];

   always #5 clk = ~clk;

   uart_rx_os_if #(.DATA_BITS(8)) if_a ();
   uart_rx_os_if #(.DATA_BITS(8)) if_b ();

   uart_rx_os #(.CLK_HZ(16_000_000), .BAUD0(100_000), .BAUD1(250_000), .BAUD2(500_000),
                .BAUD3(1_000_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                .FIFO_DEPTH(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .rx_input(rx_a), .brate_selection(sel_a),
      .rx_out(if_a), .overrun(ovr_a), .clr_overrun(clr_a), .busy(busy_a));

   uart_rx_os #(.CLK_HZ(16_000_000), .BAUD0(100_000), .BAUD1(250_000), .BAUD2(500_000),
                .BAUD3(1_000_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2),
                .FIFO_DEPTH(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .rx_input(rx_b), .brate_selection(sel_b),
      .rx_out(if_b), .overrun(ovr_b), .clr_overrun(clr_b), .busy(busy_b));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // 8N1 frame on dut_a followed by one idle bit time.
   task automatic send_a(input logic [7:0] d, input int bl);
      rx_a = 1'b0; cyc(bl);
      for (int i = 0; i < 8; i++) begin rx_a = d[i]; cyc(bl); end
      rx_a = 1'b1; cyc(bl);
      cyc(bl);
   endtask

   // 8E2 frame on dut_b with explicit parity bit and second stop bit.
   task automatic send_b(input logic [7:0] d, input logic pbit, input logic s2, input int bl);
      rx_b = 1'b0; cyc(bl);
      for (int i = 0; i < 8; i++) begin rx_b = d[i]; cyc(bl); end
      rx_b = pbit; cyc(bl);
      rx_b = 1'b1; cyc(bl);
      rx_b = s2;   cyc(bl);
      rx_b = 1'b1; cyc(bl);
   endtask

   task automatic pop_chk(input bit w, input logic [7:0] d, input logic pe, input logic fe,
                          input string tag);
      int n = 0;
      while (!(w ? if_b.out_valid : if_a.out_valid) && n < 1000) begin cyc(1); n++; end
      chk({tag, ".valid"}, w ? if_b.out_valid : if_a.out_valid, 1);
      chk({tag, ".data"},  w ? if_b.out_data : if_a.out_data, d);
      chk({tag, ".perr"},  w ? if_b.out_parity_err : if_a.out_parity_err, pe);
      chk({tag, ".ferr"},  w ? if_b.out_frame_err : if_a.out_frame_err, fe);
      if (w) if_b.out_ready = 1'b1; else if_a.out_ready = 1'b1;
      cyc(1);
      if_a.out_ready = 1'b0;
      if_b.out_ready = 1'b0;
   endtask

   initial begin
      int n;
      logic [7:0] d;
      logic pb, s2;
      ent_t e;

      rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1; sel_a = 2'd3; sel_b = 2'd3;
      clr_a = 1'b0; clr_b = 1'b0; if_a.out_ready = 1'b0; if_b.out_ready = 1'b0;
      cyc(3);
      chk("rst.data", if_a.out_data, 0);
      chk("rst.valid", if_a.out_valid, 0);
      chk("rst.errs", {if_a.out_parity_err, if_a.out_frame_err}, 0);
      chk("rst.overrun", ovr_a, 0);
      chk("rst.busy", busy_a, 0);
      rst_n = 1'b1;
      cyc(4);

      // 8N1 basic with output latency measured from the stop-bit mid-point on the pin
      d = 8'hA5;
      rx_a = 1'b0; cyc(16);
      for (int i = 0; i < 8; i++) begin rx_a = d[i]; cyc(16); end
      rx_a = 1'b1; cyc(8);
      n = 0;
      while (!if_a.out_valid && n < 20) begin cyc(1); n++; end
      chk("t1.latency_le_5", (n <= 5) ? 1 : 0, 1);
      cyc(24);
      pop_chk(0, 8'hA5, 0, 0, "t1");
      chk("t1.empty", if_a.out_valid, 0);

      // Even parity: 0x3C has even weight, so parity bit 0 is correct
      send_b(8'h3C, 1'b1, 1'b1, 16);
      pop_chk(1, 8'h3C, 1, 0, "t2.bad_par");
      send_b(8'h3C, 1'b0, 1'b1, 16);
      pop_chk(1, 8'h3C, 0, 0, "t2.good_par");
      send_b(8'h81, 1'b0, 1'b0, 16);
      pop_chk(1, 8'h81, 0, 1, "t2.stop2_low");

      // False start
      rx_a = 1'b0; cyc(5);
      chk("t3.busy_high", busy_a, 1);
      rx_a = 1'b1; cyc(7);
      chk("t3.busy_low", busy_a, 0);
      cyc(40);
      chk("t3.no_entry", if_a.out_valid, 0);

      // Break: 20 bit times low yields exactly one framing-error entry
      rx_a = 1'b0; cyc(320);
      rx_a = 1'b1; cyc(32);
      pop_chk(0, 8'h00, 0, 1, "t4.break");
      chk("t4.single", if_a.out_valid, 0);
      send_a(8'h5A, 16);
      pop_chk(0, 8'h5A, 0, 0, "t4.after");

      // FIFO overflow with consumer stalled
      for (int i = 1; i <= 4; i++) send_a(8'(i), 16);
      chk("t5.no_overrun_yet", ovr_a, 0);
      send_a(8'h05, 16);
      chk("t5.overrun", ovr_a, 1);
      for (int i = 1; i <= 4; i++) pop_chk(0, 8'(i), 0, 0, "t5.drain");
      chk("t5.drained", if_a.out_valid, 0);
      chk("t5.overrun_sticky", ovr_a, 1);
      clr_a = 1'b1; cyc(1); clr_a = 1'b0; cyc(1);
      chk("t5.cleared", ovr_a, 0);

      // Random 8N1 frames queued then drained against the model
      for (int k = 0; k < 4; k++) begin
         d = 8'($urandom);
         send_a(d, 16);
         exp_q.push_back('{d: d, pe: 1'b0, fe: 1'b0});
      end
      chk("ra.no_overrun", ovr_a, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         pop_chk(0, e.d, e.pe, e.fe, "ra");
      end

      // Random 8E2 frames with occasional bad parity or low second stop bit
      for (int k = 0; k < 6; k++) begin
         d  = 8'($urandom);
         pb = ^d ^ ($urandom_range(0, 2) == 0);
         s2 = ($urandom_range(0, 3) != 0);
         send_b(d, pb, s2, 16);
         exp_q.push_back('{d: d, pe: (pb != ^d), fe: ~s2});
         e = exp_q.pop_front();
         pop_chk(1, e.d, e.pe, e.fe, "rb");
      end

      // Baud switch mid-frame takes effect on the next frame only
      d = 8'($urandom);
      rx_a = 1'b0; cyc(16);
      sel_a = 2'd2;
      for (int i = 0; i < 8; i++) begin rx_a = d[i]; cyc(16); end
      rx_a = 1'b1; cyc(32);
      pop_chk(0, d, 0, 0, "t6.cur_frame");
      d = 8'($urandom);
      send_a(d, 32);
      pop_chk(0, d, 0, 0, "t6.next_slow");
      sel_a = 2'd3;
      cyc(4);

      // Reset mid-frame with an entry already queued
      send_a(8'h11, 16);
      chk("t6.queued", if_a.out_valid, 1);
      rx_a = 1'b0; cyc(40);
      chk("t6.busy_mid", busy_a, 1);
      rst_n = 1'b0; rx_a = 1'b1; #1;
      chk("t6.rst_valid", if_a.out_valid, 0);
      chk("t6.rst_data", if_a.out_data, 0);
      chk("t6.rst_busy", busy_a, 0);
      chk("t6.rst_ovr", ovr_a, 0);
      cyc(3);
      rst_n = 1'b1;
      cyc(200);
      chk("t6.no_entry", if_a.out_valid, 0);
      chk("t6.idle", busy_a, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
